// File: rtl/core_pkg.sv
// Shared definitions for the core register files: FSM states, default
// geometry and a helper for locating a port's slice in a packed bus.
package core_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  localparam int unsigned CORE_WIDTH      = 32;
  localparam int unsigned CORE_ADDR_WIDTH = 5;
  localparam int unsigned CORE_DEPTH      = 32;

  // Low bit of port 'port' in a bus built from 'w'-bit slices.
  function automatic int unsigned port_lo(input int unsigned port, input int unsigned w);
    return port * w;
  endfunction

endpackage

// File: rtl/regfile_wr_arb.sv
// Write-port arbiter: decides which enabled write ports actually commit.
// A port commits when writes are accepted, its address is legal and no
// higher-index port is committing to the same address.
module regfile_wr_arb
  import core_pkg::*;
#(
  parameter int unsigned NUM_WR     = 2,
  parameter int unsigned ADDR_WIDTH = CORE_ADDR_WIDTH,
  parameter int unsigned DEPTH      = CORE_DEPTH,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                         accept,
  input  logic [NUM_WR-1:0]            we,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  output logic [NUM_WR-1:0]            commit
);

  logic [ADDR_WIDTH-1:0] addr [NUM_WR];
  logic [NUM_WR-1:0]     valid;

  // Unpack addresses and qualify each port on its own
  always_comb begin
    valid = '0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      addr[j]  = wr_addr[port_lo(j, ADDR_WIDTH) +: ADDR_WIDTH];
      valid[j] = accept && we[j] && (32'(addr[j]) < DEPTH) &&
                 !((ZERO_REG != 0) && (addr[j] == '0));
    end
  end

  // Drop any port shadowed by a higher-index valid port on the same address
  always_comb begin
    commit = valid;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      for (int unsigned k = j + 1; k < NUM_WR; k++) begin
        if (valid[k] && (addr[k] == addr[j])) begin
          commit[j] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-port priority, a clear sequencer
// that zeroes the array after reset or on request, and a ready flag.
// Optional same-cycle write-to-read forwarding: REGFILE_MP_BYPASS_EN.
module regfile_mp
  import core_pkg::*;
#(
  parameter int unsigned WIDTH      = CORE_WIDTH,
  parameter int unsigned ADDR_WIDTH = CORE_ADDR_WIDTH,
  parameter int unsigned DEPTH      = CORE_DEPTH,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 2,
  parameter int unsigned ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_req,
  output logic                         ready,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]      rd_dout,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_WR*WIDTH-1:0]      wr_din,
  input  logic [NUM_WR-1:0]            we
);

  localparam logic [ADDR_WIDTH-1:0] CLR_FIRST = ADDR_WIDTH'(ZERO_REG);
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST  = ADDR_WIDTH'(DEPTH - 1);

  rf_state_t             state, state_next;
  logic [ADDR_WIDTH-1:0] clr_ptr, clr_ptr_next;
  logic                  accept;
  logic [NUM_WR-1:0]     commit;
  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] ra;

  // State and clear pointer register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RF_CLEAR;
      clr_ptr <= CLR_FIRST;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
    end
  end

  // Next state: sweep the array in CLEAR, return to CLEAR on request
  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    case (state)
      RF_CLEAR: begin
        clr_ptr_next = clr_ptr + ADDR_WIDTH'(1);
        if (clr_ptr == CLR_LAST) begin
          state_next = RF_READY;
        end
      end
      RF_READY: begin
        if (clr_req) begin
          state_next   = RF_CLEAR;
          clr_ptr_next = CLR_FIRST;
        end
      end
      default: state_next = RF_CLEAR;
    endcase
  end

  // Outputs: ready flag and user-write acceptance (a clear request edge takes no writes)
  always_comb begin
    ready  = (state == RF_READY);
    accept = (state == RF_READY) && !clr_req;
  end

  regfile_wr_arb #(
    .NUM_WR     (NUM_WR),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .ZERO_REG   (ZERO_REG)
  ) u_wr_arb (
    .accept  (accept),
    .we      (we),
    .wr_addr (wr_addr),
    .commit  (commit)
  );

  // Array update: clear sweep or committed user writes (committed addresses are unique)
  always_ff @(posedge clk) begin
    if (state == RF_CLEAR) begin
      mem[clr_ptr] <= '0;
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (commit[j]) begin
          mem[wr_addr[port_lo(j, ADDR_WIDTH) +: ADDR_WIDTH]] <= wr_din[port_lo(j, WIDTH) +: WIDTH];
        end
      end
    end
  end

  // Read ports: zero in CLEAR, for out-of-range addresses and for the zero register
  always_comb begin
    rd_dout = '0;
    ra      = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[port_lo(k, ADDR_WIDTH) +: ADDR_WIDTH];
      if ((state == RF_READY) && (32'(ra) < DEPTH) && !((ZERO_REG != 0) && (ra == '0))) begin
        rd_dout[port_lo(k, WIDTH) +: WIDTH] = mem[ra];
`ifdef REGFILE_MP_BYPASS_EN
        // Commit mask already encodes priority, so at most one port matches
        for (int unsigned j = 0; j < NUM_WR; j++) begin
          if (commit[j] && (wr_addr[port_lo(j, ADDR_WIDTH) +: ADDR_WIDTH] == ra)) begin
            rd_dout[port_lo(k, WIDTH) +: WIDTH] = wr_din[port_lo(j, WIDTH) +: WIDTH];
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances (ZERO_REG=1 and ZERO_REG=0) share the
// stimulus and are checked every cycle against a behavioural model.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr_req = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_din = '0;
  logic [1:0]  we = '0;
  logic [63:0] rd_dout, rd_dout_nz;
  logic        ready, ready_nz;

  int checks = 0;
  int failures = 0;

  // model state, index 0 = ZERO_REG=1 instance, index 1 = ZERO_REG=0 instance
  logic [31:0] mem_m [2][32];
  bit          rdy_m [2];
  int          clr_m [2];

  always #5 clk = ~clk;

  regfile_mp #(.ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready),
    .rd_addr(rd_addr), .rd_dout(rd_dout),
    .wr_addr(wr_addr), .wr_din(wr_din), .we(we)
  );

  regfile_mp #(.ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst), .clr_req(clr_req), .ready(ready_nz),
    .rd_addr(rd_addr), .rd_dout(rd_dout_nz),
    .wr_addr(wr_addr), .wr_din(wr_din), .we(we)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int zr_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic void model_reset(input int i);
    rdy_m[i] = 1'b0;
    clr_m[i] = 32 - zr_of(i);
    for (int a = 0; a < 32; a++) mem_m[i][a] = '0;
  endfunction

  function automatic logic [31:0] exp_read(input int i, input logic [4:0] a);
    logic [31:0] r;
    if (!rdy_m[i]) return '0;
    if (zr_of(i) == 1 && a == 5'd0) return '0;
    r = mem_m[i][a];
`ifdef REGFILE_MP_BYPASS_EN
    if (!clr_req) begin
      for (int j = 0; j < 2; j++) begin
        if (we[j] && wr_addr[j*5 +: 5] == a) r = wr_din[j*32 +: 32];
      end
    end
`endif
    return r;
  endfunction

  function automatic void model_update();
    logic [4:0] a;
    for (int i = 0; i < 2; i++) begin
      if (!rdy_m[i]) begin
        clr_m[i]--;
        if (clr_m[i] == 0) rdy_m[i] = 1'b1;
      end else if (clr_req) begin
        model_reset(i);
      end else begin
        for (int j = 0; j < 2; j++) begin
          a = wr_addr[j*5 +: 5];
          if (we[j] && !(zr_of(i) == 1 && a == 5'd0)) mem_m[i][a] = wr_din[j*32 +: 32];
        end
      end
    end
  endfunction

  task automatic compare_all();
    check_eq("ready", {31'd0, ready}, {31'd0, rdy_m[0]});
    check_eq("ready_nz", {31'd0, ready_nz}, {31'd0, rdy_m[1]});
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("rd%0d", k), rd_dout[k*32 +: 32], exp_read(0, rd_addr[k*5 +: 5]));
      check_eq($sformatf("rd%0d_nz", k), rd_dout_nz[k*32 +: 32], exp_read(1, rd_addr[k*5 +: 5]));
    end
  endtask

  // compare mid-cycle, then advance model with the DUT edge
  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic rand_inputs(input int clr_odds);
    we = 2'($urandom_range(0, 3));
    for (int j = 0; j < 2; j++) begin
      wr_addr[j*5 +: 5] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      wr_din[j*32 +: 32] = $urandom;
    end
    for (int k = 0; k < 2; k++) begin
      rd_addr[k*5 +: 5] = ($urandom_range(0, 2) == 0) ? wr_addr[k*5 +: 5] : 5'($urandom);
    end
    clr_req = (clr_odds > 0) && ($urandom_range(0, clr_odds - 1) == 0);
  endtask

  // count edges until the ZERO_REG=1 instance is ready, with random traffic
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      rand_inputs(3);
      step();
      n++;
    end
    check_eq(tag, n, 31);
    we = '0;
    clr_req = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp;
    model_reset(0);
    model_reset(1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b1;
    wait_ready("clear_len_reset");

    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(31 - i), 5'(i)};
      #1;
      check_eq("init_zero", rd_dout_nz[31:0], 32'h0);
      step();
    end

    we = 2'b01;
    wr_addr[4:0] = 5'd5;
    wr_din[31:0] = 32'hDEADBEEF;
    rd_addr[4:0] = 5'd5;
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    exp = 32'hDEADBEEF;
`else
    exp = 32'h0;
`endif
    check_eq("same_cycle", rd_dout[31:0], exp);
    step();
    we = '0;
    #1;
    check_eq("after_write", rd_dout[31:0], 32'hDEADBEEF);
    step();

    we = 2'b11;
    wr_addr = {5'd7, 5'd7};
    wr_din = {32'h22222222, 32'h11111111};
    step();
    we = '0;
    rd_addr[4:0] = 5'd7;
    #1;
    check_eq("conflict", rd_dout[31:0], 32'h22222222);
    check_eq("conflict_nz", rd_dout_nz[31:0], 32'h22222222);
    step();

    we = 2'b01;
    wr_addr[4:0] = 5'd0;
    wr_din[31:0] = 32'hFFFFFFFF;
    step();
    we = '0;
    rd_addr[4:0] = 5'd0;
    #1;
    check_eq("zero_reg", rd_dout[31:0], 32'h0);
    check_eq("zero_reg_off", rd_dout_nz[31:0], 32'hFFFFFFFF);
    step();

    we = 2'b11;
    wr_addr = {5'd9, 5'd3};
    wr_din = {32'hA5A5_0009, 32'h5A5A_0003};
    step();
    we = '0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check_eq("clr_ready_drop", {31'd0, ready}, 32'd0);
    wait_ready("clear_len_req");
    rd_addr = {5'd9, 5'd3};
    #1;
    check_eq("clr_r3", rd_dout[31:0], 32'h0);
    check_eq("clr_r9", rd_dout[63:32], 32'h0);
    step();

    repeat (400) begin
      rand_inputs(60);
      step();
    end

    we = '0;
    clr_req = 1'b0;
    for (int n = 0; n < 80 && !(ready === 1'b1 && ready_nz === 1'b1); n++) step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (9) begin
      rand_inputs(0);
      step();
    end
    rst = 1'b0;
    model_reset(0);
    model_reset(1);
    #2;
    compare_all();
    rst = 1'b1;
    wait_ready("clear_len_midrst");
    repeat (20) begin
      rand_inputs(0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file and successor to the single-write, two-read core register file.
- Configurable read-port count, write-port count, width and depth.
- Adds a deterministic write-port priority, an on-chip clear sequencer (entries are zeroed after reset and on request) and a ready handshake.
- Sits in the decode/writeback boundary of the core; one write port per retiring lane.

Parameters:
- WIDTH, 32, data width of each entry.
- ADDR_WIDTH, 5, address width; must satisfy 2**ADDR_WIDTH >= DEPTH.
- DEPTH, 32, number of entries.
- NUM_RD, 2, number of combinational read ports.
- NUM_WR, 2, number of synchronous write ports.
- ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes; 0 = entry 0 is an ordinary entry.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low.
- clr_req  in  1  level request to re-run the clear sequence; sampled only in READY.
- ready  out  1  high when the array is valid and writes are accepted.
- rd_addr  in  NUM_RD*ADDR_WIDTH  read addresses; port k is slice [k*ADDR_WIDTH +: ADDR_WIDTH].
- rd_dout  out  NUM_RD*WIDTH  read data; port k is slice [k*WIDTH +: WIDTH].
- wr_addr  in  NUM_WR*ADDR_WIDTH  write addresses, sliced per port.
- wr_din  in  NUM_WR*WIDTH  write data, sliced per port.
- we  in  NUM_WR  per-port write enable.

Behaviour:
- FSM states:
  - CLEAR, encoded 1'b0.
  - READY, encoded 1'b1.
- Reset:
  - rst low forces state=CLEAR and clr_ptr = ZERO_REG ? 1 : 0.
  - ready is 0 during reset.
  - Array contents are not reset directly.
- CLEAR:
  - Each cycle writes 0 to entry clr_ptr, then clr_ptr increments.
  - When clr_ptr == DEPTH-1 is written, next state is READY.
  - Duration is DEPTH-ZERO_REG cycles (31 at defaults).
  - All we are ignored; all rd_dout read 0; ready=0.
- READY:
  - ready=1.
  - clr_req=1 sampled on a clock edge: that edge performs no user writes; next state CLEAR with clr_ptr reloaded; ready drops on the following cycle.
  - clr_req is ignored while in CLEAR.
- Writes, in READY only:
  - A port with we[j]=1 writes wr_din[j] to wr_addr[j] at the rising edge.
  - Addresses >= DEPTH are dropped.
  - With ZERO_REG=1, writes to address 0 are dropped.
  - Same-cycle same-address conflict: the highest-index enabled port wins; lower ports to that address are dropped.
  - Writes to different addresses all commit.
- Reads:
  - Combinational; rd_dout[k] = array[rd_addr[k]].
  - Result is 0 when ZERO_REG=1 and the address is 0.
  - Result is 0 when the address is >= DEPTH.
  - Result is 0 in CLEAR.
  - Without the bypass feature, a read of an address being written this cycle returns the old value.
- Reset mid-clear: restarts the sequence from the first entry, with no partial-ready pulse.
- Outputs are fully defined every cycle, with no X on rd_dout after the first CLEAR completes.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined: a read whose address matches an enabled, accepted write in the same cycle (READY, address legal) returns that write's wr_din. Priority follows the write rule (highest index wins). Zero-register and CLEAR rules still override.
- Undefined: read-old-value behaviour as above; no forwarding logic is synthesised.

Decomposition:
- Shared package core_pkg holds:
  - the FSM state encoding constants RF_CLEAR and RF_READY;
  - the default WIDTH/ADDR_WIDTH/DEPTH values used by the core;
  - a helper function for per-port slice offsets.
- One natural sub-module: regfile_wr_arb. It is combinational per-address winner selection across NUM_WR ports and outputs a per-port commit mask. The same arbiter feeds both the array write and the bypass mux.

Test Plan:
- Reset release, defaults: ready stays 0 for exactly 31 cycles, then goes 1; reads of addresses 0..31 all return 0x00000000.
- READY, we=2'b01, wr_addr0=5, wr_din0=0xDEADBEEF: the next cycle rd_addr0=5 returns 0xDEADBEEF. The same cycle returns the old value 0, or 0xDEADBEEF with REGFILE_MP_BYPASS_EN.
- Conflict: we=2'b11, both ports address 7, data 0x11111111 on port 0 and 0x22222222 on port 1; address 7 then reads 0x22222222.
- ZERO_REG=1, we[0]=1, addr 0, data 0xFFFFFFFF: address 0 still reads 0. With ZERO_REG=0 the same write reads back 0xFFFFFFFF.
- Registers 3 and 9 are written, then clr_req is pulsed for 1 cycle:
  - ready falls the next cycle;
  - we is ignored during CLEAR;
  - after 31 cycles ready=1 and registers 3 and 9 read 0.
- rst asserted at CLEAR cycle 10 and released: ready remains 0 for a full 31 cycles from release; there is no early ready.
